// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one result bit per clock, LSB first,
// behind a start/done handshake with a single carry/borrow flip-flop.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow,
  output logic             overflow
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             mode_q, mode_d;
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             cb_q, cb_d;
  logic             ovf_q, ovf_d;

  logic             ai, bi, bit_s, c_next;
  logic [WIDTH-1:0] r_next;

  // Full adder for add; full subtractor (a - b - borrow) for subtract.
  assign ai     = a_q[0];
  assign bi     = b_q[0];
  assign bit_s  = ai ^ bi ^ c_q;
  assign c_next = mode_q ? ((~ai & bi) | (~(ai ^ bi) & c_q))
                         : ((ai & bi) | (ai & c_q) | (bi & c_q));
  assign r_next = {bit_s, r_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every next-state signal starts from its current value, so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    mode_d   = mode_q;
    am_d     = am_q;
    bm_d     = bm_q;
    cb_d     = cb_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          am_d    = a[WIDTH-1];
          bm_d    = b[WIDTH-1];
          c_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = r_next;
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The exported fields change only on entry to DONE and hold through IDLE.
          state_d  = DONE;
          result_d = r_next;
          cb_d     = c_next;
          ovf_d    = (mode_q ? (am_q != bm_q) : (am_q == bm_q)) && (bit_s != am_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      mode_q   <= 1'b0;
      am_q     <= 1'b0;
      bm_q     <= 1'b0;
      cb_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      am_q     <= am_d;
      bm_q     <= bm_d;
      cb_q     <= cb_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign result       = result_q;
  assign carry_borrow = cb_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: 8-bit directed/random ops and an exhaustive
// 4-bit sweep, compared against a plain-arithmetic model.
module tb_serial_add_sub;

  typedef struct {
    logic [31:0] r;
    logic        cb;
    logic        ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cb8, ovf8;
  logic [7:0] result8;

  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cb4, ovf4;
  logic [3:0] result4;

  int total = 0;
  int bad   = 0;

  exp_t        exp8[1024];
  exp_t        exp4[1024];
  int          wr8 = 0, rd8 = 0, wr4 = 0, rd4 = 0;
  logic [31:0] h8r = '0, h4r = '0;
  logic        h8cb = 1'b0, h8ov = 1'b0, h4cb = 1'b0, h4ov = 1'b0;
  int          n_done4 = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry_borrow(cb8), .overflow(ovf8)
  );

  serial_add_sub #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carry_borrow(cb4), .overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input int w, input bit m, input int ua, input int ub);
    exp_t e;
    int   mm, sa, sb, full, sfull;
    mm    = 1 << w;
    sa    = (ua >= mm / 2) ? ua - mm : ua;
    sb    = (ub >= mm / 2) ? ub - mm : ub;
    full  = m ? ua - ub : ua + ub;
    sfull = m ? sa - sb : sa + sb;
    e.r   = 32'((full + mm) % mm);
    e.cb  = m ? (ua < ub) : (full >= mm);
    e.ov  = (sfull >= mm / 2) || (sfull < -(mm / 2));
    return e;
  endfunction

  // Compare processes: on done the fields must match the oldest pending operation;
  // on every other cycle they must hold the last completed values.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      rd8  = wr8;
      h8r  = '0;
      h8cb = 1'b0;
      h8ov = 1'b0;
    end else if (done8) begin
      if (rd8 == wr8) begin
        check("u8_spurious_done", 32'd1, 32'd0);
      end else begin
        check("u8_result", 32'(result8), exp8[rd8].r);
        check("u8_carry_borrow", 32'(cb8), 32'(exp8[rd8].cb));
        check("u8_overflow", 32'(ovf8), 32'(exp8[rd8].ov));
        h8r  = exp8[rd8].r;
        h8cb = exp8[rd8].cb;
        h8ov = exp8[rd8].ov;
        rd8++;
      end
    end else begin
      check("u8_hold_result", 32'(result8), h8r);
      check("u8_hold_cb", 32'(cb8), 32'(h8cb));
      check("u8_hold_ovf", 32'(ovf8), 32'(h8ov));
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      rd4  = wr4;
      h4r  = '0;
      h4cb = 1'b0;
      h4ov = 1'b0;
    end else if (done4) begin
      n_done4++;
      if (rd4 == wr4) begin
        check("u4_spurious_done", 32'd1, 32'd0);
      end else begin
        check("u4_result", 32'(result4), exp4[rd4].r);
        check("u4_carry_borrow", 32'(cb4), 32'(exp4[rd4].cb));
        check("u4_overflow", 32'(ovf4), 32'(exp4[rd4].ov));
        h4r  = exp4[rd4].r;
        h4cb = exp4[rd4].cb;
        h4ov = exp4[rd4].ov;
        rd4++;
      end
    end else begin
      check("u4_hold_result", 32'(result4), h4r);
    end
  end

  // Issue one 8-bit operation and wait (bounded) for its done cycle.
  task automatic op8(input bit m, input logic [7:0] x, input logic [7:0] y,
                     output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    start8 = 1'b1;
    mode8  = m;
    a8     = x;
    b8     = y;
    exp8[wr8] = model(8, m, int'(x), int'(y));
    wr8++;
    while (!seen && lat < 40) begin
      @(negedge clk);
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      mode8  = 1'($urandom);
      lat++;
      if (busy8) bcnt++;
      if (done8) seen = 1'b1;
    end
    if (!seen) check("op8_timeout", 32'd0, 32'd1);
  endtask

  task automatic op4(input bit m, input logic [3:0] x, input logic [3:0] y);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    @(negedge clk);
    start4 = 1'b1;
    mode4  = m;
    a4     = x;
    b4     = y;
    exp4[wr4] = model(4, m, int'(x), int'(y));
    wr4++;
    while (!seen && n < 20) begin
      @(negedge clk);
      start4 = 1'b0;
      n++;
      if (done4) seen = 1'b1;
    end
    if (!seen) check("op4_timeout", 32'd0, 32'd1);
  endtask

  task automatic lit8(input string name, input logic [7:0] r, input logic cb, input logic ov);
    check({name, "_result"}, 32'(result8), 32'(r));
    check({name, "_cb"}, 32'(cb8), 32'(cb));
    check({name, "_ovf"}, 32'(ovf8), 32'(ov));
  endtask

  initial begin
    int lat, bc, n;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_cb", 32'(cb8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    rst = 1'b0;

    // Basic add with latency and busy-length checks
    op8(1'b0, 8'h3C, 8'h05, lat, bc);
    check("t1_latency", 32'(lat), 32'd9);
    check("t1_busy_cycles", 32'(bc), 32'd9);
    lit8("t1", 8'h41, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy8), 32'd0);

    // Subtraction both ways
    op8(1'b1, 8'h05, 8'h3C, lat, bc);
    lit8("t2a", 8'hC9, 1'b1, 1'b0);
    op8(1'b1, 8'h3C, 8'h05, lat, bc);
    lit8("t2b", 8'h37, 1'b0, 1'b0);

    // Boundary cases, issued back-to-back
    op8(1'b0, 8'hFF, 8'h01, lat, bc);
    lit8("t3_ff_plus_1", 8'h00, 1'b1, 1'b0);
    op8(1'b0, 8'h7F, 8'h01, lat, bc);
    lit8("t3_7f_plus_1", 8'h80, 1'b0, 1'b1);
    op8(1'b1, 8'h80, 8'h01, lat, bc);
    lit8("t3_80_minus_1", 8'h7F, 1'b0, 1'b1);
    op8(1'b1, 8'h00, 8'h00, lat, bc);
    lit8("t3_0_minus_0", 8'h00, 1'b0, 1'b0);

    // start ignored while busy, including the DONE cycle
    @(negedge clk);
    start8 = 1'b1;
    mode8  = 1'b0;
    a8     = 8'h10;
    b8     = 8'h20;
    exp8[wr8] = model(8, 1'b0, 32'h10, 32'h20);
    wr8++;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      start8 = 1'b0;
      if (n == 3 || done8) begin
        start8 = 1'b1;
        mode8  = 1'b1;
        a8     = 8'hAA;
        b8     = 8'h55;
      end
      if (done8) begin
        seen = 1'b1;
        check("t4_result", 32'(result8), 32'h30);
      end
    end
    check("t4_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    start8 = 1'b0;
    check("t4_no_restart", 32'(busy8), 32'd0);
    repeat (10) @(negedge clk);
    check("t4_still_idle", 32'(busy8), 32'd0);

    // Reset mid-operation abandons the operation
    @(negedge clk);
    start8 = 1'b1;
    mode8  = 1'b1;
    a8     = 8'h50;
    b8     = 8'h10;
    exp8[wr8] = model(8, 1'b1, 32'h50, 32'h10);
    wr8++;
    repeat (4) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_result", 32'(result8), 32'd0);
    repeat (12) @(negedge clk);
    op8(1'b0, 8'h01, 8'h01, lat, bc);
    lit8("t5_after", 8'h02, 1'b0, 1'b0);

    // Random 8-bit operations with random idle gaps
    for (int i = 0; i < 150; i++) begin
      op8(1'($urandom), 8'($urandom), 8'($urandom), lat, bc);
      check("rand_latency", 32'(lat), 32'd9);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Exhaustive 4-bit sweep, back-to-back
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(1'(m), 4'(x), 4'(y));

    repeat (3) @(negedge clk);
    check("u4_done_count", 32'(n_done4), 32'd512);
    check("u8_all_completed", 32'(rd8), 32'(wr8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
